// File: rtl/cli_console_ctrl_pkg.sv
// Shared constants, state encoding and character helpers for the CLI console controller.
// CLI_CLEAR_EN adds the clear-screen state to the encoding.
package cli_pkg;

   localparam int CLI_COLS = 100;
   localparam int CLI_ROWS = 38;
   localparam int CLI_AW   = 12;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_TILDE = 8'h7E;
   localparam logic [7:0] CHAR_LF    = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CPU_WR = 3'd1,
      ST_KB_WR  = 3'd2,
      ST_KB_NL  = 3'd3
`ifdef CLI_CLEAR_EN
      ,
      ST_CLR    = 3'd4
`endif
   } cli_ctrl_state_t;

   typedef enum logic {
      GNT_KB  = 1'b0,
      GNT_CPU = 1'b1
   } cli_grant_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CHAR_SPACE) && (c <= CHAR_TILDE);
   endfunction

endpackage

// File: rtl/cli_console_ctrl_if.sv
// Bundle of requester handshakes, tracker controls and RAM write port.
// The controller uses the slave view; the surrounding system uses the master view.
interface cli_console_ctrl_if #(parameter int AW = cli_pkg::CLI_AW);
   logic          kb_valid;
   logic [7:0]    kb_char;
   logic          kb_ready;
   logic          cpu_req;
   logic [6:0]    cpu_x;
   logic [5:0]    cpu_y;
   logic [7:0]    cpu_char;
   logic          cpu_ack;
   logic          trk_sel_cpu;
   logic          trk_inc;
   logic [6:0]    trk_cpu_x;
   logic [5:0]    trk_cpu_y;
   logic [6:0]    trk_x;
   logic [5:0]    trk_y;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          clr_req;
   logic          clr_busy;

   modport slave (
      input  kb_valid, kb_char, cpu_req, cpu_x, cpu_y, cpu_char, trk_x, trk_y, clr_req,
      output kb_ready, cpu_ack, trk_sel_cpu, trk_inc, trk_cpu_x, trk_cpu_y,
             wr_en, wr_addr, wr_data, clr_busy
   );

   modport master (
      output kb_valid, kb_char, cpu_req, cpu_x, cpu_y, cpu_char, trk_x, trk_y, clr_req,
      input  kb_ready, cpu_ack, trk_sel_cpu, trk_inc, trk_cpu_x, trk_cpu_y,
             wr_en, wr_addr, wr_data, clr_busy
   );
endinterface

// File: rtl/cli_console_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (CPU vs keyboard); on a tie the requester
// that did not win last time is granted. last_grant resets to KB.
module cli_rr_arb2
   import cli_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_req_cpu,
   input  logic i_req_kb,
   input  logic i_update,
   output logic o_gnt_cpu,
   output logic o_gnt_kb
);

   cli_grant_t r_last;

   // Grant decode from current requests and the last winner.
   always_comb begin
      o_gnt_cpu = 1'b0;
      o_gnt_kb  = 1'b0;
      if (i_req_cpu && (!i_req_kb || (r_last == GNT_KB))) begin
         o_gnt_cpu = 1'b1;
      end else if (i_req_kb) begin
         o_gnt_kb = 1'b1;
      end else begin
         o_gnt_cpu = 1'b0;
         o_gnt_kb  = 1'b0;
      end
   end

   // Remember the winner only when the grant is actually consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= GNT_KB;
      end else if (i_update && o_gnt_cpu) begin
         r_last <= GNT_CPU;
      end else if (i_update && o_gnt_kb) begin
         r_last <= GNT_KB;
      end else begin
         r_last <= r_last;
      end
   end

endmodule

// File: rtl/cli_console_ctrl.sv
// Arbitrates CPU and keyboard writes into the character RAM via the position tracker.
// Optional clear-screen sweep is compiled in with CLI_CLEAR_EN.
module cli_console_ctrl
   import cli_pkg::*;
#(
   parameter int COLS = CLI_COLS,
   parameter int ROWS = CLI_ROWS,
   parameter int AW   = CLI_AW
)
(
   input  logic               clk,
   input  logic               rst,
   cli_console_ctrl_if.slave  bus
);

   cli_ctrl_state_t r_state;
   logic            r_wr_en;
   logic            r_trk_inc;
   logic            r_cpu_ack;
   logic            r_sel_cpu;
   logic [6:0]      r_cpu_x;
   logic [5:0]      r_cpu_y;
   logic [7:0]      r_wr_data;
   logic            r_clr_busy;
   logic [AW-1:0]   r_clr_cnt;

   logic            w_gnt_cpu;
   logic            w_gnt_kb;
   logic            w_idle;
   logic            w_clr_start;
   logic            w_cpu_in_range;
   logic            w_at_last_col;
   logic [AW-1:0]   w_lin_addr;

   assign w_idle         = (r_state == ST_IDLE);
   assign w_cpu_in_range = (int'(bus.cpu_x) < COLS) && (int'(bus.cpu_y) < ROWS);
   assign w_at_last_col  = (int'(bus.trk_x) == (COLS - 1));
   assign w_lin_addr     = AW'(bus.trk_y) * AW'(COLS) + AW'(bus.trk_x);

`ifdef CLI_CLEAR_EN
   assign w_clr_start = w_idle && bus.clr_req;
`else
   logic w_unused_clr;
   assign w_clr_start  = 1'b0;
   assign w_unused_clr = bus.clr_req;
   assign r_clr_busy   = 1'b0;
   assign r_clr_cnt    = '0;
`endif

   cli_rr_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req_cpu (bus.cpu_req),
      .i_req_kb  (bus.kb_valid),
      .i_update  (w_idle && !w_clr_start),
      .o_gnt_cpu (w_gnt_cpu),
      .o_gnt_kb  (w_gnt_kb)
   );

   // Ready is the only combinational handshake: it must reflect this cycle's arbitration.
   assign bus.kb_ready    = w_idle && !rst && !w_gnt_cpu && !w_clr_start;
   assign bus.cpu_ack     = r_cpu_ack;
   assign bus.trk_sel_cpu = r_sel_cpu;
   assign bus.trk_inc     = r_trk_inc;
   assign bus.trk_cpu_x   = r_cpu_x;
   assign bus.trk_cpu_y   = r_cpu_y;
   assign bus.wr_en       = r_wr_en;
   assign bus.wr_data     = r_wr_data;
   assign bus.clr_busy    = r_clr_busy;
`ifdef CLI_CLEAR_EN
   assign bus.wr_addr     = (r_state == ST_CLR) ? r_clr_cnt : w_lin_addr;
`else
   assign bus.wr_addr     = w_lin_addr;
`endif

   // Sequencer: strobes are set one cycle ahead so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_wr_en   <= 1'b0;
         r_trk_inc <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_sel_cpu <= 1'b0;
         r_cpu_x   <= 7'd0;
         r_cpu_y   <= 6'd0;
         r_wr_data <= 8'd0;
`ifdef CLI_CLEAR_EN
         r_clr_busy <= 1'b0;
         r_clr_cnt  <= '0;
`endif
      end else begin
         r_wr_en   <= 1'b0;
         r_trk_inc <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_sel_cpu <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_clr_start) begin
`ifdef CLI_CLEAR_EN
                  r_state    <= ST_CLR;
                  r_wr_en    <= 1'b1;
                  r_wr_data  <= CHAR_SPACE;
                  r_clr_cnt  <= '0;
                  r_clr_busy <= 1'b1;
`else
                  r_state    <= ST_IDLE;
`endif
               end else if (w_gnt_cpu) begin
                  r_state   <= ST_CPU_WR;
                  r_cpu_x   <= bus.cpu_x;
                  r_cpu_y   <= bus.cpu_y;
                  r_wr_data <= bus.cpu_char;
                  r_sel_cpu <= 1'b1;
                  r_cpu_ack <= 1'b1;
                  r_wr_en   <= w_cpu_in_range;
               end else if (w_gnt_kb) begin
                  if (is_printable(bus.kb_char)) begin
                     r_state   <= ST_KB_WR;
                     r_wr_data <= bus.kb_char;
                     r_wr_en   <= 1'b1;
                     r_trk_inc <= 1'b1;
                  end else if (bus.kb_char == CHAR_LF) begin
                     r_state   <= ST_KB_NL;
                     r_trk_inc <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_CPU_WR: r_state <= ST_IDLE;
            ST_KB_WR:  r_state <= ST_IDLE;
            ST_KB_NL: begin
               // Keep stepping until the cycle that sits on the last column.
               if (w_at_last_col) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state   <= ST_KB_NL;
                  r_trk_inc <= 1'b1;
               end
            end
`ifdef CLI_CLEAR_EN
            ST_CLR: begin
               if (int'(r_clr_cnt) == (COLS * ROWS - 1)) begin
                  r_state    <= ST_IDLE;
                  r_clr_busy <= 1'b0;
               end else begin
                  r_state   <= ST_CLR;
                  r_wr_en   <= 1'b1;
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cli_console_ctrl.sv
// Directed bench for cli_console_ctrl with a behavioural tracker model.
// Build with CLI_CLEAR_EN defined to exercise the clear-screen sweep.
module tb_cli_console_ctrl;
   import cli_pkg::*;

   logic       clk;
   logic       rst;
   logic [6:0] tx;
   logic [5:0] ty;
   logic [6:0] rst_x;
   logic [5:0] rst_y;
   int         n_vec;
   int         n_miss;

   cli_console_ctrl_if #(.AW(CLI_AW)) bus ();

   cli_console_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tracker model: CPU coordinates pass straight through while selected.
   assign bus.trk_x = bus.trk_sel_cpu ? bus.trk_cpu_x : tx;
   assign bus.trk_y = bus.trk_sel_cpu ? bus.trk_cpu_y : ty;

   always @(posedge clk) begin
      if (rst) begin
         tx <= rst_x;
         ty <= rst_y;
      end else if (bus.trk_inc) begin
         if (tx == 7'd99) begin
            tx <= 7'd0;
            ty <= (ty == 6'd37) ? 6'd0 : ty + 6'd1;
         end else begin
            tx <= tx + 7'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic [6:0] x, input logic [5:0] y);
      rst          = 1'b1;
      rst_x        = x;
      rst_y        = y;
      bus.kb_valid = 1'b0;
      bus.kb_char  = 8'd0;
      bus.cpu_req  = 1'b0;
      bus.cpu_x    = 7'd0;
      bus.cpu_y    = 6'd0;
      bus.cpu_char = 8'd0;
      bus.clr_req  = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec  = 0;
      n_miss = 0;

      // Reset state, sampled while reset is still held.
      do_reset(7'd0, 6'd0);
      rst = 1'b1;
      #1;
      chk("rst_wr_en", bus.wr_en, 1'b0);
      chk("rst_inc", bus.trk_inc, 1'b0);
      chk("rst_ack", bus.cpu_ack, 1'b0);
      chk("rst_ready", bus.kb_ready, 1'b0);
      chk("rst_sel", bus.trk_sel_cpu, 1'b0);
      chk("rst_cx", bus.trk_cpu_x, 7'd0);
      chk("rst_cy", bus.trk_cpu_y, 6'd0);
      chk("rst_data", bus.wr_data, 8'd0);
      chk("rst_busy", bus.clr_busy, 1'b0);

      // CPU write at (5,2).
      rst          = 1'b0;
      bus.cpu_req  = 1'b1;
      bus.cpu_x    = 7'd5;
      bus.cpu_y    = 6'd2;
      bus.cpu_char = 8'h41;
      #1;
      chk("cpu_ready_lo", bus.kb_ready, 1'b0);
      cyc();
      chk("cpu_wr_en", bus.wr_en, 1'b1);
      chk("cpu_addr", bus.wr_addr, 12'd205);
      chk("cpu_data", bus.wr_data, 8'h41);
      chk("cpu_ack", bus.cpu_ack, 1'b1);
      chk("cpu_sel", bus.trk_sel_cpu, 1'b1);
      chk("cpu_inc", bus.trk_inc, 1'b0);
      bus.cpu_req = 1'b0;
      cyc();
      chk("cpu_ack_end", bus.cpu_ack, 1'b0);
      chk("cpu_wr_end", bus.wr_en, 1'b0);
      chk("cpu_sel_end", bus.trk_sel_cpu, 1'b0);
      chk("idle_ready", bus.kb_ready, 1'b1);

      // Out-of-range CPU column is acked without a write.
      bus.cpu_req = 1'b1;
      bus.cpu_x   = 7'd100;
      bus.cpu_y   = 6'd0;
      cyc();
      chk("oor_ack", bus.cpu_ack, 1'b1);
      chk("oor_wr", bus.wr_en, 1'b0);
      bus.cpu_req = 1'b0;
      cyc();

      // Keyboard 'H','i' from (0,0).
      do_reset(7'd0, 6'd0);
      bus.kb_valid = 1'b1;
      bus.kb_char  = 8'h48;
      #1;
      chk("kb_ready_h", bus.kb_ready, 1'b1);
      cyc();
      chk("kb_h_wr", bus.wr_en, 1'b1);
      chk("kb_h_addr", bus.wr_addr, 12'd0);
      chk("kb_h_data", bus.wr_data, 8'h48);
      chk("kb_h_inc", bus.trk_inc, 1'b1);
      chk("kb_h_ready", bus.kb_ready, 1'b0);
      bus.kb_char = 8'h69;
      cyc();
      chk("kb_gap_wr", bus.wr_en, 1'b0);
      chk("kb_gap_ready", bus.kb_ready, 1'b1);
      cyc();
      chk("kb_i_wr", bus.wr_en, 1'b1);
      chk("kb_i_addr", bus.wr_addr, 12'd1);
      chk("kb_i_data", bus.wr_data, 8'h69);
      chk("kb_i_inc", bus.trk_inc, 1'b1);
      chk("kb_i_ready", bus.kb_ready, 1'b0);
      bus.kb_valid = 1'b0;
      cyc();
      chk("kb_end_wr", bus.wr_en, 1'b0);
      chk("kb_end_inc", bus.trk_inc, 1'b0);

      // Control code other than LF: accepted, no write, no advance.
      bus.kb_valid = 1'b1;
      bus.kb_char  = 8'h07;
      #1;
      chk("bel_ready", bus.kb_ready, 1'b1);
      cyc();
      bus.kb_valid = 1'b0;
      chk("bel_wr", bus.wr_en, 1'b0);
      chk("bel_inc", bus.trk_inc, 1'b0);
      chk("bel_addr", bus.wr_addr, 12'd2);

      // Newline from x=97, row 4: three increments then idle at (0,5).
      do_reset(7'd97, 6'd4);
      bus.kb_valid = 1'b1;
      bus.kb_char  = CHAR_LF;
      #1;
      chk("nl_ready", bus.kb_ready, 1'b1);
      cyc();
      bus.kb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("nl_inc", bus.trk_inc, 1'b1);
         chk("nl_wr", bus.wr_en, 1'b0);
         chk("nl_ready_lo", bus.kb_ready, 1'b0);
         cyc();
      end
      chk("nl_done_inc", bus.trk_inc, 1'b0);
      chk("nl_done_addr", bus.wr_addr, 12'd500);
      chk("nl_done_ready", bus.kb_ready, 1'b1);

      // Continuous contention from reset: CPU, KB, CPU, KB.
      do_reset(7'd0, 6'd0);
      bus.cpu_req  = 1'b1;
      bus.cpu_x    = 7'd1;
      bus.cpu_y    = 6'd0;
      bus.cpu_char = 8'h43;
      bus.kb_valid = 1'b1;
      bus.kb_char  = 8'h4B;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk("rr_ack", bus.cpu_ack, (k == 1 || k == 5) ? 1'b1 : 1'b0);
         chk("rr_inc", bus.trk_inc, (k == 3 || k == 7) ? 1'b1 : 1'b0);
         chk("rr_wr", bus.wr_en, (k % 2 == 1) ? 1'b1 : 1'b0);
      end

      // Reset in the grant cycle: no write, no ack.
      do_reset(7'd0, 6'd0);
      bus.cpu_req = 1'b1;
      bus.cpu_x   = 7'd3;
      bus.cpu_y   = 6'd1;
      rst         = 1'b1;
      cyc();
      chk("ab_wr", bus.wr_en, 1'b0);
      chk("ab_ack", bus.cpu_ack, 1'b0);
      chk("ab_sel", bus.trk_sel_cpu, 1'b0);
      chk("ab_inc", bus.trk_inc, 1'b0);
      chk("ab_ready", bus.kb_ready, 1'b0);
      chk("ab_cx", bus.trk_cpu_x, 7'd0);
      bus.cpu_req = 1'b0;
      rst         = 1'b0;
      cyc();
      chk("ab_ack2", bus.cpu_ack, 1'b0);
      chk("ab_wr2", bus.wr_en, 1'b0);

`ifdef CLI_CLEAR_EN
      begin
         int cnt;
         int bad;
         cnt = 0;
         bad = 0;
         do_reset(7'd0, 6'd0);
         bus.kb_valid = 1'b1;
         bus.kb_char  = 8'h5A;
         bus.clr_req  = 1'b1;
         #1;
         chk("clr_ready_lo", bus.kb_ready, 1'b0);
         cyc();
         bus.clr_req = 1'b0;
         while (bus.clr_busy === 1'b1 && cnt < 4000) begin
            if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'(cnt) ||
                bus.wr_data !== 8'h20 || bus.kb_ready !== 1'b0 ||
                bus.trk_inc !== 1'b0 || bus.cpu_ack !== 1'b0) begin
               bad++;
            end
            cnt++;
            cyc();
         end
         chk("clr_len", cnt, 3800);
         chk("clr_bad", bad, 0);
         chk("clr_after_wr", bus.wr_en, 1'b0);
         chk("clr_after_ready", bus.kb_ready, 1'b1);
      end
`else
      do_reset(7'd0, 6'd0);
      bus.clr_req = 1'b1;
      #1;
      chk("noclr_busy", bus.clr_busy, 1'b0);
      chk("noclr_ready", bus.kb_ready, 1'b1);
      cyc();
      bus.clr_req = 1'b0;
      chk("noclr_busy2", bus.clr_busy, 1'b0);
      chk("noclr_wr", bus.wr_en, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
